expr_eval_p: RTL and testbench
==============================

# expr_eval_p

Parametrised expression engine for the online-test datapath. It accepts a fixed-length burst of 5-bit-style tokens and, depending on a per-burst mode, does one of three things: evaluate a prefix expression, evaluate a postfix expression, or convert an infix expression to postfix. Each burst produces one registered result word with a one-cycle `out_valid` pulse. It generalises the single-size prefix/infix block to any operand count and width, adds the postfix-evaluate mode, and adds divide-by-zero and stack-fault reporting.

## Interface
- `N`, 10: operand count per expression. A burst is `T = 2N-1` tokens.
- `OPND_W`, 4: unsigned operand width. Token width is `OPND_W+1`.
- `ACC_W`, 64: signed evaluation width. Must satisfy `ACC_W <= OUT_W`.
- `OUT_W`, `(2N-1)*(OPND_W+1)`: output width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-high reset (1 = reset).
- `in_valid`  in  1  token strobe; high for exactly T consecutive cycles per burst.
- `mode`  in  2  sampled on the first `in_valid` cycle only.
  - 0 = prefix evaluate
  - 1 = postfix evaluate
  - 2 = infix to postfix
  - 3 = reserved, behaves as 0.
- `in_data`  in  OPND_W+1  token.
  - MSB=0: operand = low OPND_W bits.
  - MSB=1: operator from bits[1:0]: 00 `+`, 01 `-`, 10 `*`, 11 `/`. Other bits are ignored.
- `out_valid`  out  1  one-cycle result strobe. Reset 0.
- `out`  out  OUT_W  result. Reset 0; 0 whenever `out_valid`=0.
- `err`  out  1  fault flag, valid with `out_valid`. Reset 0; 0 whenever `out_valid`=0.

## Operation
- States: IDLE, LOAD, EVAL, CONV, FLUSH, DONE.
- IDLE -> LOAD when `in_valid`=1. The first token is stored and `mode` is latched.
- LOAD stores T tokens in a token buffer indexed 0..T-1 in arrival order.
- LOAD -> EVAL (mode 0/1/3) or CONV (mode 2) on the cycle after the last token.
- EVAL handles exactly one token per cycle, using an operand stack of depth N and width ACC_W.
  - Scan order: mode 0/3 scans index T-1 down to 0; mode 1 scans 0 up to T-1.
  - Operand token: zero-extend and push.
  - Operator token: pop two, push result.
    - Mode 0: left = first pop, right = second pop.
    - Mode 1: right = first pop, left = second pop.
  - Arithmetic is two's complement modulo 2^ACC_W.
  - Division truncates toward zero.
  - Divide by zero: push 0 and set sticky `err`.
  - Push when the stack is full, or pop when it is empty: set sticky `err`; the stack is left unchanged.
  - After the last token, if the stack holds anything other than exactly one entry, set `err`.
- CONV runs shunting-yard with no parentheses. `*` and `/` have precedence over `+` and `-`. Operators are left-associative. The operator stack has depth N-1.
  - Operand: append to the output queue, 1 cycle.
  - Operator: while the stack top has precedence >= incoming, pop one entry to the queue per cycle. Then push, 1 cycle.
- CONV -> FLUSH after the last token. FLUSH pops one operator to the queue per cycle until the stack is empty.
- EVAL, or FLUSH when empty, -> DONE.
- DONE drives `out_valid`=1 for one cycle, then -> IDLE.
  - Eval modes: `out` = final stack value, sign-extended to OUT_W. If `err`=1, `out`=0.
  - Mode 2: `out` = queue packed with queue[0] in bits [OUT_W-1 -: OPND_W+1], `err`=0.
- `in_valid` outside IDLE/LOAD is ignored.
- A new burst may start in the cycle after `out_valid`.
- Reset mid-operation: `rst_n`=1 immediately clears state to IDLE, and clears `out_valid`, `out`, `err` and the stack pointers. The partial burst is discarded. Buffer contents need not be cleared.

## Timing
- Let t0 be the cycle of the last `in_valid`.
- Eval modes: EVAL occupies t0+1 .. t0+T. DONE is at t0+T+1, so `out_valid` is seen high in cycle t0+T+1. Latency is fixed.
- Mode 2: latency is variable. `out_valid` falls within t0+T+1 .. t0+T+N (at most N-1 extra pop cycles in total).
- Input to output is fully registered; there is no combinational path from `in_valid` to `out_valid`.

## Test plan
Tests use N=4, OPND_W=4, ACC_W=32, so OUT_W=35.
- Prefix mode 0, `+ * 3 4 - 9 2` -> `out`=19, `err`=0, `out_valid` exactly 8 cycles after the last token.
- Postfix mode 1, `3 4 * 9 2 - +` -> `out`=19, same latency.
- Prefix `/ - 1 8 + 1 1` -> `out`=-3 (sign-extended, 35'h7_FFFF_FFFD), `err`=0.
- Prefix `/ + 7 1 - 3 3` -> `out`=0, `err`=1.
- Infix mode 2, `3 + 4 * 9 - 2` -> `out` = tokens `3 4 9 * + 2 -` packed as {00011,00100,01001,10010,10000,00010,10001}. `out_valid` arrives no later than t0+11.
- Back-to-back and reset:
  - Start a second burst in the cycle after `out_valid`; both results must be correct.
  - Pulse `rst_n` high for one cycle during EVAL: no `out_valid`, all outputs 0, and the next burst evaluates correctly.

Source files
------------

// File: rtl/expr_eval_p.sv
// rtl/expr_eval_p.sv - prefix/postfix evaluator and infix-to-postfix converter
// Buffers one token burst, then either evaluates it on an operand stack or reorders it with shunting-yard.
module expr_eval_p #(
  parameter int N      = 10,
  parameter int OPND_W = 4,
  parameter int ACC_W  = 64,
  parameter int OUT_W  = (2*N-1)*(OPND_W+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic [OPND_W:0]   in_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out,
  output logic              err
);
  localparam int T  = 2*N-1;
  localparam int TW = OPND_W+1;
  localparam int CW = $clog2(T);
  localparam int QW = $clog2(T+1);
  localparam int SW = $clog2(N+1);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(T-1);

  typedef enum logic [2:0] {IDLE, LOAD, EVAL, CONV, FLUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sp_q, sp_d;
  logic [IW-1:0] osp_q, osp_d;
  logic [QW-1:0] qp_q, qp_d;
  logic          err_q, err_d;

  logic [TW-1:0]           buf_q [T];
  logic signed [ACC_W-1:0] stk_q [N];
  logic [TW-1:0]           ops_q [N];
  logic [TW-1:0]           q_q   [T];

  logic                    buf_we, stk_we, q_we, ops_we;
  logic [CW-1:0]           buf_wa;
  logic [IW-1:0]           stk_wa;
  logic signed [ACC_W-1:0] stk_wd;
  logic [TW-1:0]           q_wd;

  logic                    post, div0;
  logic [CW-1:0]           scan_idx;
  logic [TW-1:0]           tok, top;
  logic signed [ACC_W-1:0] pop1, pop2, lhs, rhs, res;
  logic [OUT_W-1:0]        pack;

  // Prefix (mode 0/3) walks the buffer backwards; postfix and conversion walk it forwards.
  assign post     = (mode_q == 2'd1);
  assign scan_idx = (mode_q == 2'd0 || mode_q == 2'd3) ? LAST - cnt_q : cnt_q;
  assign tok      = buf_q[scan_idx];
  assign top      = ops_q[osp_q - IW'(1)];
  assign pop1     = stk_q[IW'(sp_q - SW'(1))];
  assign pop2     = stk_q[IW'(sp_q - SW'(2))];
  assign lhs      = post ? pop2 : pop1;
  assign rhs      = post ? pop1 : pop2;

  always_comb begin
    res  = '0;
    div0 = 1'b0;
    case (tok[1:0])
      2'b00:   res = lhs + rhs;
      2'b01:   res = lhs - rhs;
      2'b10:   res = lhs * rhs;
      default: begin
        if (rhs == '0) div0 = 1'b1;
        else           res  = lhs / rhs;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    osp_d   = osp_q;
    qp_d    = qp_q;
    err_d   = err_q;
    buf_we  = 1'b0;
    buf_wa  = cnt_q;
    stk_we  = 1'b0;
    stk_wa  = IW'(sp_q);
    stk_wd  = '0;
    q_we    = 1'b0;
    q_wd    = tok;
    ops_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = LOAD;
          mode_d  = mode;
          buf_we  = 1'b1;
          buf_wa  = '0;
          cnt_d   = CW'(1);
          sp_d    = '0;
          osp_d   = '0;
          qp_d    = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = (mode_q == 2'd2) ? CONV : EVAL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      EVAL: begin
        // Stack faults leave the stack untouched and only raise the sticky flag.
        if (!tok[TW-1]) begin
          if (sp_q == SW'(N)) err_d = 1'b1;
          else begin
            stk_we = 1'b1;
            stk_wd = ACC_W'(tok[OPND_W-1:0]);
            sp_d   = sp_q + SW'(1);
          end
        end else if (sp_q < SW'(2)) begin
          err_d = 1'b1;
        end else begin
          stk_we = 1'b1;
          stk_wa = IW'(sp_q - SW'(2));
          stk_wd = res;
          sp_d   = sp_q - SW'(1);
          if (div0) err_d = 1'b1;
        end
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      CONV: begin
        if (tok[TW-1] && osp_q != '0 && top[1] >= tok[1]) begin
          q_wd  = top;
          osp_d = osp_q - IW'(1);
          if (qp_q < QW'(T)) begin
            q_we = 1'b1;
            qp_d = qp_q + QW'(1);
          end
        end else begin
          if (!tok[TW-1]) begin
            if (qp_q < QW'(T)) begin
              q_we = 1'b1;
              qp_d = qp_q + QW'(1);
            end
          end else if (osp_q < IW'(N-1)) begin
            ops_we = 1'b1;
            osp_d  = osp_q + IW'(1);
          end
          if (cnt_q == LAST) state_d = FLUSH;
          else               cnt_d   = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        // The final pop and the move to DONE share a cycle.
        if (osp_q != '0) begin
          q_wd  = top;
          osp_d = osp_q - IW'(1);
          if (qp_q < QW'(T)) begin
            q_we = 1'b1;
            qp_d = qp_q + QW'(1);
          end
        end
        if (osp_q <= IW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      sp_q    <= '0;
      osp_q   <= '0;
      qp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      osp_q   <= osp_d;
      qp_q    <= qp_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_wa]      <= in_data;
    if (stk_we) stk_q[stk_wa]      <= stk_wd;
    if (q_we)   q_q[CW'(qp_q)]     <= q_wd;
    if (ops_we) ops_q[osp_q]       <= tok;
  end

  always_comb begin
    pack = '0;
    for (int i = 0; i < T; i++) pack[OUT_W-1-i*TW -: TW] = q_q[i];
  end

  always_comb begin
    out_valid = 1'b0;
    out       = '0;
    err       = 1'b0;
    if (state_q == DONE) begin
      out_valid = 1'b1;
      if (mode_q == 2'd2) begin
        out = pack;
      end else begin
        err = err_q | (sp_q != SW'(1));
        if (!err) out = OUT_W'(stk_q[0]);
      end
    end
  end

endmodule

// File: tb/tb_expr_eval_p.sv
// tb/tb_expr_eval_p.sv - scoreboard bench for expr_eval_p
module tb_expr_eval_p;
  localparam int N = 4, OPND_W = 4, ACC_W = 32, OUT_W = 35, T = 7;
  localparam logic [4:0] ADD = 5'b10000, SUB = 5'b10001, MUL = 5'b10010, DIV = 5'b10011;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [4:0]       in_data = 5'd0;
  logic             out_valid;
  logic [OUT_W-1:0] out;
  logic             err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [OUT_W-1:0] out;
    logic             err;
    int               lat_min;
    int               lat_max;
  } exp_t;
  exp_t sb[$];

  expr_eval_p #(.N(N), .OPND_W(OPND_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .in_data(in_data), .out_valid(out_valid), .out(out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input logic [OUT_W-1:0] eo, input logic ee, input int lmin, input int lmax);
    exp_t e;
    e.out = eo; e.err = ee; e.lat_min = lmin; e.lat_max = lmax;
    sb.push_back(e);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle t0+1. Mode is garbled after the first token.
  task automatic send(input logic [1:0] m, input logic [34:0] seq);
    for (int i = 0; i < T; i++) begin
      in_valid = 1'b1;
      in_data  = seq[34-5*i -: 5];
      mode     = (i == 0) ? m : ~m;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 5'd0;
    mode     = 2'd2;
  endtask

  task automatic receive(input string tag);
    int k;
    exp_t e;
    k = 1;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (k >= e.lat_min && k <= e.lat_max) else begin
        errors++;
        $error("FAIL %s_lat observed %0d expected %0d..%0d", tag, k, e.lat_min, e.lat_max);
      end
      check({tag, "_out"}, 64'(out), 64'(e.out));
      check({tag, "_err"}, 64'(err), 64'(e.err));
    end
    @(negedge clk);
    check({tag, "_pulse_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_pulse_out"}, 64'(out), 64'd0);
    check({tag, "_pulse_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);

    expect_res(35'd19, 1'b0, 8, 8);
    send(2'd0, {ADD, MUL, 5'd3, 5'd4, SUB, 5'd9, 5'd2});
    receive("pre19");

    expect_res(35'd19, 1'b0, 8, 8);
    send(2'd1, {5'd3, 5'd4, MUL, 5'd9, 5'd2, SUB, ADD});
    receive("post19");

    expect_res(35'h7_FFFF_FFFD, 1'b0, 8, 8);
    send(2'd0, {DIV, SUB, 5'd1, 5'd8, ADD, 5'd1, 5'd1});
    receive("pre_neg3");

    expect_res(35'd0, 1'b1, 8, 8);
    send(2'd0, {DIV, ADD, 5'd7, 5'd1, SUB, 5'd3, 5'd3});
    receive("pre_div0");

    expect_res({5'b00011, 5'b00100, 5'b01001, MUL, ADD, 5'b00010, SUB}, 1'b0, 8, 11);
    send(2'd2, {5'd3, ADD, 5'd4, MUL, 5'd9, SUB, 5'd2});
    receive("infix");

    expect_res(35'd1, 1'b0, 8, 8);
    send(2'd3, {SUB, 5'd9, MUL, 5'd2, ADD, 5'd3, 5'd1});
    receive("mode3");

    expect_res(35'd0, 1'b1, 8, 8);
    send(2'd1, {ADD, 5'd1, 5'd2, 5'd3, 5'd4, MUL, MUL});
    receive("post_fault");

    send(2'd0, {ADD, MUL, 5'd3, 5'd4, SUB, 5'd9, 5'd2});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    rst_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || out != '0 || err) seen++;
    end
    check("midrst_quiet", 64'(seen), 64'd0);

    expect_res(35'd19, 1'b0, 8, 8);
    send(2'd1, {5'd3, 5'd4, MUL, 5'd9, 5'd2, SUB, ADD});
    receive("after_rst");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
